// File: rtl/xorshift_txn_gen_pkg.sv
// Shared definitions for xorshift64 transaction generators: the step function,
// the generator FSM states and the default seed upper half.
package xorshift_pkg;

   localparam logic [31:0] XS_DEFAULT_SEED_HI = 32'h9E37_79B9;

   typedef enum logic [2:0] {
      XS_IDLE,
      XS_LOAD,
      XS_OFFER,
      XS_GAP,
      XS_DONE
   } xs_state_e;

   // Marsaglia xorshift64 (13, 7, 17); bits shifted out are discarded.
   function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
      logic [63:0] x1;
      logic [63:0] x2;
      x1 = x ^ (x << 13);
      x2 = x1 ^ (x1 >> 7);
      return x2 ^ (x2 << 17);
   endfunction

endpackage

// File: rtl/xorshift_txn_gen_if.sv
// Valid/ready word stream carrying 64-bit generated transactions.
interface xorshift_txn_gen_if;
   logic        data_vld;
   logic        data_rdy;
   logic [63:0] data;

   modport master (output data_vld, output data, input data_rdy);
   modport slave  (input data_vld, input data, output data_rdy);
endinterface

// File: rtl/xorshift_txn_gen.sv
// Produces NB_TRANSACTIONS xorshift64 words seeded from {SEED_HI, cpu_index},
// offered on a valid/ready stream with optional idle gaps between beats.
module xorshift_txn_gen
   import xorshift_pkg::*;
#(
   parameter int unsigned  NB_TRANSACTIONS = 16,
   parameter int unsigned  GAP_CYCLES      = 0,
   parameter logic [31:0]  SEED_HI         = XS_DEFAULT_SEED_HI
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [31:0]                cpu_index,
   xorshift_txn_gen_if.master         data_if,
   output logic [31:0]                txn_count,
   output logic                       transactions_done,
   output logic                       busy
);

   localparam logic [31:0] NB_L  = 32'(NB_TRANSACTIONS);
   localparam logic [31:0] GAP_L = 32'(GAP_CYCLES);

   xs_state_e   state_reg, state_next;
   logic [63:0] state_x_reg, state_x_next;
   logic [63:0] data_reg, data_next;
   logic [31:0] txn_count_reg, txn_count_next;
   logic [31:0] gap_reg, gap_next;
   logic [63:0] step_x;
   logic [31:0] count_inc;

   assign step_x    = xorshift64_step(state_x_reg);
   assign count_inc = txn_count_reg + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= XS_IDLE;
         state_x_reg   <= '0;
         data_reg      <= '0;
         txn_count_reg <= '0;
         gap_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         state_x_reg   <= state_x_next;
         data_reg      <= data_next;
         txn_count_reg <= txn_count_next;
         gap_reg       <= gap_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      state_x_next   = state_x_reg;
      data_next      = data_reg;
      txn_count_next = txn_count_reg;
      gap_next       = gap_reg;
      case (state_reg)
         XS_IDLE, XS_DONE: begin
            if (start) begin
               if (NB_L == 32'd0) begin
                  state_next = XS_DONE;
               end else begin
                  state_x_next   = {SEED_HI, cpu_index};
                  txn_count_next = '0;
                  state_next     = XS_LOAD;
               end
            end
         end
         XS_LOAD: begin
            state_x_next = step_x;
            data_next    = step_x;
            state_next   = XS_OFFER;
         end
         XS_OFFER: begin
            if (data_if.data_rdy) begin
               txn_count_next = count_inc;
               if (count_inc == NB_L) begin
                  state_next = XS_DONE;
               end else if (GAP_L == 32'd0) begin
                  // state_x still holds the word just accepted, so step it now
                  state_x_next = step_x;
                  data_next    = step_x;
               end else begin
                  gap_next   = GAP_L - 32'd1;
                  state_next = XS_GAP;
               end
            end
         end
         XS_GAP: begin
            if (gap_reg == 32'd0) begin
               state_next = XS_LOAD;
            end else begin
               gap_next = gap_reg - 32'd1;
            end
         end
         default: state_next = XS_IDLE;
      endcase
   end

   // Valid decodes straight from the async-reset state, so it drops with rst_n.
   assign data_if.data_vld  = (state_reg == XS_OFFER);
   assign data_if.data      = data_reg;
   assign txn_count         = txn_count_reg;
   assign transactions_done = (state_reg == XS_DONE);
   assign busy              = (state_reg == XS_LOAD) || (state_reg == XS_OFFER) ||
                              (state_reg == XS_GAP);

endmodule

// File: tb/tb_xorshift_txn_gen.sv
// Checks three generator configurations (4 words back-to-back, 3 words with
// 2-cycle gaps, 0 words) against a plain xorshift64 reference model.
module tb_xorshift_txn_gen;

   localparam logic [31:0] SEED_HI = 32'h9E37_79B9;

   logic        clk;
   logic        rst_n;
   logic        a_start, b_start, c_start;
   logic [31:0] a_cpu, b_cpu, c_cpu;
   logic [31:0] a_cnt, b_cnt, c_cnt;
   logic        a_done, b_done, c_done;
   logic        a_busy, b_busy, c_busy;
   int          checks;
   int          failures;

   xorshift_txn_gen_if a_if ();
   xorshift_txn_gen_if b_if ();
   xorshift_txn_gen_if c_if ();

   xorshift_txn_gen #(.NB_TRANSACTIONS(4), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(a_start), .cpu_index(a_cpu), .data_if(a_if),
      .txn_count(a_cnt), .transactions_done(a_done), .busy(a_busy));

   xorshift_txn_gen #(.NB_TRANSACTIONS(3), .GAP_CYCLES(2)) u_gap (
      .clk(clk), .rst_n(rst_n), .start(b_start), .cpu_index(b_cpu), .data_if(b_if),
      .txn_count(b_cnt), .transactions_done(b_done), .busy(b_busy));

   xorshift_txn_gen #(.NB_TRANSACTIONS(0), .GAP_CYCLES(0)) u_zero (
      .clk(clk), .rst_n(rst_n), .start(c_start), .cpu_index(c_cpu), .data_if(c_if),
      .txn_count(c_cnt), .transactions_done(c_done), .busy(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: xorshift64 written directly from its definition.
   function automatic logic [63:0] ref_next(input logic [63:0] x);
      logic [63:0] y;
      y = x;
      y = y ^ (y << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   task automatic pulse_a(input logic [31:0] cpu);
      a_cpu = cpu; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   // Runs instance A from just after start until done, optionally with random back-pressure.
   task automatic drain_a(input logic [63:0] seed, input bit rand_rdy, input string tag);
      logic [63:0] x, held;
      int beats, stall;
      bit stalled, hs_prev, finished;
      x = ref_next(seed); held = '0;
      beats = 0; stall = 0; stalled = 0; hs_prev = 0; finished = 0;
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         if (a_if.data_vld) begin
            checks++;
            if (beats >= 4 || a_if.data !== x) begin
               failures++; $display("FAIL %s_word beat=%0d got=%h exp=%h", tag, beats, a_if.data, x);
            end
            checks++;
            if (a_cnt !== beats) begin
               failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, a_cnt, beats);
            end
            if (stalled) begin
               checks++;
               if (a_if.data !== held) begin
                  failures++; $display("FAIL %s_hold got=%h exp=%h", tag, a_if.data, held);
               end
            end
         end
         if (a_done) begin
            checks++;
            if (!hs_prev || beats != 4) begin
               failures++; $display("FAIL %s_done_timing hs_prev=%0d beats=%0d exp=4", tag, hs_prev, beats);
            end
            finished = 1;
         end else begin
            a_if.data_rdy = rand_rdy ? ((stall >= 5) || ($urandom_range(0, 1) == 1)) : 1'b1;
            hs_prev = a_if.data_vld && a_if.data_rdy;
            if (hs_prev) begin
               $display("%s beat %0d data=%h", tag, beats, a_if.data);
               beats++; x = ref_next(x); stall = 0; stalled = 0;
            end else if (a_if.data_vld) begin
               stall++; stalled = 1; held = a_if.data;
            end
            @(negedge clk);
         end
      end
      checks++;
      if (!finished) begin
         failures++; $display("FAIL %s_timeout got=not_done exp=done", tag);
      end
      checks++;
      if (a_cnt !== 32'd4 || a_if.data_vld !== 1'b0 || a_busy !== 1'b0) begin
         failures++; $display("FAIL %s_final cnt=%0d vld=%b busy=%b exp=4/0/0", tag, a_cnt, a_if.data_vld, a_busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_start = 0; b_start = 0; c_start = 0;
      a_cpu = 0; b_cpu = 0; c_cpu = 0;
      a_if.data_rdy = 1'b1; b_if.data_rdy = 1'b1; c_if.data_rdy = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({a_if.data_vld, a_if.data, a_cnt, a_done, a_busy} !== '0) begin
         failures++; $display("FAIL reset_a vld=%b data=%h cnt=%0d done=%b busy=%b exp=all0",
                              a_if.data_vld, a_if.data, a_cnt, a_done, a_busy);
      end
      checks++;
      if ({b_if.data_vld, b_done, b_busy, c_if.data_vld, c_done, c_busy} !== 6'b0) begin
         failures++; $display("FAIL reset_bc got=%b exp=000000",
                              {b_if.data_vld, b_done, b_busy, c_if.data_vld, c_done, c_busy});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero();
      checks++;
      if (c_done !== 1'b0) begin
         failures++; $display("FAIL zero_predone got=%b exp=0", c_done);
      end
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      checks++;
      if (c_done !== 1'b1 || c_busy !== 1'b0 || c_if.data_vld !== 1'b0) begin
         failures++; $display("FAIL zero_done done=%b busy=%b vld=%b exp=1/0/0", c_done, c_busy, c_if.data_vld);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (c_if.data_vld !== 1'b0 || c_done !== 1'b1) begin
            failures++; $display("FAIL zero_hold vld=%b done=%b exp=0/1", c_if.data_vld, c_done);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] x;
      x = {SEED_HI, 32'd0};
      a_if.data_rdy = 1'b1;
      pulse_a(32'd0);
      checks++;
      if (a_if.data_vld !== 1'b0 || a_busy !== 1'b1) begin
         failures++; $display("FAIL b2b_load vld=%b busy=%b exp=0/1", a_if.data_vld, a_busy);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         x = ref_next(x);
         $display("b2b beat %0d data=%h", k, a_if.data);
         checks++;
         if (a_if.data_vld !== 1'b1 || a_if.data !== x || a_cnt !== k) begin
            failures++; $display("FAIL b2b_beat%0d vld=%b data=%h cnt=%0d exp=1/%h/%0d",
                                 k, a_if.data_vld, a_if.data, a_cnt, x, k);
         end
      end
      @(negedge clk);
      checks++;
      if (a_done !== 1'b1 || a_if.data_vld !== 1'b0 || a_cnt !== 32'd4 || a_busy !== 1'b0) begin
         failures++; $display("FAIL b2b_done done=%b vld=%b cnt=%0d busy=%b exp=1/0/4/0",
                              a_done, a_if.data_vld, a_cnt, a_busy);
      end
   endtask

   task automatic test_gap();
      logic [63:0] x;
      logic [31:0] cpu;
      int beats, last;
      bit seen_done;
      cpu = $urandom;
      x = ref_next({SEED_HI, cpu});
      beats = 0; last = -1; seen_done = 0;
      b_if.data_rdy = 1'b1;
      b_cpu = cpu; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
         if (b_if.data_vld) begin
            $display("gap beat %0d cyc=%0d data=%h", beats, cyc, b_if.data);
            checks++;
            if (beats >= 3 || b_if.data !== x || b_cnt !== beats) begin
               failures++; $display("FAIL gap_beat%0d data=%h cnt=%0d exp=%h/%0d", beats, b_if.data, b_cnt, x, beats);
            end
            checks++;
            if ((beats == 0 && cyc != 1) || (beats > 0 && cyc - last != 4)) begin
               failures++; $display("FAIL gap_spacing beat=%0d cyc=%0d last=%0d exp_delta=4", beats, cyc, last);
            end
            last = cyc; beats++; x = ref_next(x);
         end
         if (b_done) seen_done = 1;
         else @(negedge clk);
      end
      checks++;
      if (!seen_done || beats != 3 || b_cnt !== 32'd3) begin
         failures++; $display("FAIL gap_final done=%0d beats=%0d cnt=%0d exp=1/3/3", seen_done, beats, b_cnt);
      end
   endtask

   task automatic test_backpressure();
      pulse_a(32'd0);
      drain_a({SEED_HI, 32'd0}, 1'b1, "bp");
   endtask

   task automatic test_ignored_start();
      logic [31:0] c1;
      logic [63:0] seed1;
      c1 = $urandom;
      seed1 = {SEED_HI, c1};
      a_if.data_rdy = 1'b0;
      pulse_a(c1);
      repeat (3) @(negedge clk);
      pulse_a(c1 ^ 32'h5A5A_0001);
      checks++;
      if (a_if.data_vld !== 1'b1 || a_if.data !== ref_next(seed1) || a_cnt !== 32'd0) begin
         failures++; $display("FAIL ign_start vld=%b data=%h cnt=%0d exp=1/%h/0",
                              a_if.data_vld, a_if.data, a_cnt, ref_next(seed1));
      end
      drain_a(seed1, 1'b0, "ign");
      // Restart from DONE must clear done on the start edge and repeat the run.
      pulse_a(c1);
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b1 || a_cnt !== 32'd0) begin
         failures++; $display("FAIL restart done=%b busy=%b cnt=%0d exp=0/1/0", a_done, a_busy, a_cnt);
      end
      drain_a(seed1, 1'b1, "rst");
   endtask

   task automatic test_reset_midrun();
      logic [31:0] cpu;
      logic [63:0] w1, w2;
      int waited;
      cpu = $urandom;
      w1 = ref_next({SEED_HI, cpu});
      w2 = ref_next(w1);
      a_if.data_rdy = 1'b0;
      pulse_a(cpu);
      waited = 0;
      while (!a_if.data_vld && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (a_if.data_vld !== 1'b1 || a_if.data !== w1) begin
         failures++; $display("FAIL mid_w1 vld=%b data=%h exp=1/%h", a_if.data_vld, a_if.data, w1);
      end
      a_if.data_rdy = 1'b1;
      @(negedge clk);
      a_if.data_rdy = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (a_if.data_vld !== 1'b1 || a_if.data !== w2 || a_cnt !== 32'd1) begin
         failures++; $display("FAIL mid_w2 vld=%b data=%h cnt=%0d exp=1/%h/1", a_if.data_vld, a_if.data, a_cnt, w2);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_if.data_vld, a_if.data, a_cnt, a_done, a_busy} !== '0) begin
         failures++; $display("FAIL mid_async vld=%b data=%h cnt=%0d done=%b busy=%b exp=all0",
                              a_if.data_vld, a_if.data, a_cnt, a_done, a_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a_if.data_rdy = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (a_if.data_vld !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
         failures++; $display("FAIL mid_idle vld=%b busy=%b done=%b exp=0/0/0", a_if.data_vld, a_busy, a_done);
      end
      pulse_a(32'd7);
      drain_a({SEED_HI, 32'd7}, 1'b0, "cpu7");
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_zero();
      test_back_to_back();
      test_gap();
      test_backpressure();
      test_ignored_start();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xorshift_txn_gen.md
# xorshift_txn_gen

Upstream transaction source for the per-CPU DPI client testbench. On `start`, it produces a fixed number of 64-bit xorshift64 pseudo-random words, seeded from `cpu_index`. Words are offered one per beat on a valid/ready interface. The top level forwards each accepted word to the DPI send call and waits on `transactions_done` before `$finish`. It replaces free-running generation with back-pressure, programmable inter-beat gaps and a sticky completion flag.

## Interface
- `NB_TRANSACTIONS`, default 16: words per run; 0 is legal.
- `GAP_CYCLES`, default 0: idle cycles inserted after each accepted beat before the next word is offered.
- `SEED_HI`, default 32'h9E37_79B9: upper 32 bits of the seed (nonzero, so the seed is never 0).
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `start` in 1: single-cycle request to begin a run.
- `cpu_index` in 32: seed low half; sampled on the accepted `start`.
- `data_rdy` in 1: consumer ready.
- `data_vld` out 1: word valid.
- `data` out 64: current word.
- `txn_count` out 32: number of words accepted so far in this run.
- `transactions_done` out 1: run complete (sticky).
- `busy` out 1: run in progress.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: generate next word.
  - OFFER: `data_vld`=1.
  - GAP: wait between beats.
  - DONE.
- IDLE + `start`:
  - If NB_TRANSACTIONS=0, go to DONE.
  - Otherwise latch `state_x` = {SEED_HI, cpu_index}, clear `txn_count`, go to LOAD.
- LOAD:
  - `x1` = x ^ (x<<13); `x2` = x1 ^ (x1>>7); `x3` = x2 ^ (x2<<17). All 64-bit; shifted-out bits are dropped.
  - `state_x` and `data` both take `x3`; go to OFFER.
- OFFER: hold `data` stable while `data_vld` && !`data_rdy`. On a handshake (`data_vld` && `data_rdy` at a posedge):
  - `txn_count`++.
  - If it was the last word, go to DONE.
  - Else if GAP_CYCLES=0, compute the next word in the same edge and stay in OFFER (back-to-back).
  - Else go to GAP with the gap counter at GAP_CYCLES-1.
- GAP: count down; at 0 go to LOAD.
- DONE: `transactions_done`=1, `busy`=0, `data_vld`=0. A new `start` restarts exactly as from IDLE; `transactions_done` clears on that edge.
- `start` outside IDLE/DONE is ignored, and `cpu_index` is not resampled.
- `busy` = 1 in LOAD/OFFER/GAP.
- The sequence is fully determined by (SEED_HI, `cpu_index`) and matches a C xorshift64 reference model, so the DPI server can check it.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - `data_vld`=0, `data`=0, `txn_count`=0, `transactions_done`=0, `busy`=0, `state_x`=0.
- Reset asserted mid-run:
  - `data_vld` drops immediately, without waiting for a clock.
  - The run is abandoned; after release the block waits for a new `start`.
- Latency:
  - `start` sampled at edge E0 → LOAD.
  - E1 → OFFER, with `data_vld`=1 after E1.
- Throughput: 1 word/cycle when GAP_CYCLES=0 and `data_rdy`=1. Otherwise 1 word per (GAP_CYCLES+2) cycles.
- Completion: the last handshake at edge En makes `transactions_done`=1 after En. No extra beat is ever offered.
- Valid/ready rules:
  - `data_vld` never deasserts without a handshake, except on reset.
  - `data` never changes while `data_vld` && !`data_rdy`.
  - `data_rdy` may be combinational from the consumer.
- `txn_count` wraps only above 2^32-1 (unreachable for legal NB_TRANSACTIONS).

## Structure
- Package `xorshift_pkg`:
  - Function `xorshift64_step(logic [63:0]) -> logic [63:0]`.
  - FSM state enum `xs_state_e`.
  - Constant `XS_DEFAULT_SEED_HI`.
- No sub-module; the step function is shared with any future generator and with the bench scoreboard.

## Test plan
- NB=4, GAP=0, `cpu_index`=0, `data_rdy`=1:
  - Exactly 4 consecutive beats on cycles E1..E4.
  - Words equal successive `xorshift64_step` values from 64'h9E3779B9_00000000.
  - `transactions_done`=1 after E4.
- NB=3, GAP=2, `data_rdy`=1 → beats 4 cycles apart; `txn_count` steps 1, 2, 3.
- NB=4, `data_rdy` random 50% with stalls up to 5 cycles → `data` stable while stalled; the same 4 words as the no-stall run, in order.
- NB=0, `start` → `transactions_done`=1 one cycle later; `data_vld` never asserted.
- `rst_n` pulled low in the middle of the second beat while stalled:
  - `data_vld`=0 immediately and all outputs at reset values.
  - A new `start` with `cpu_index`=7 gives a fresh sequence from seed 64'h9E3779B9_00000007.
- `start` pulsed again while in OFFER → ignored and the count is unaffected; `start` in DONE → `transactions_done` clears and the run repeats identically.
